rr_drain_arbiter: RTL and testbench

- Downstream stage of the PCIe transaction-layer block.
- Drains its four 10-bit virtual-channel FIFO outputs in round-robin order and emits one serialized word stream toward the data-link layer.
- Keeps a per-channel forwarded-word counter that can be read with a req/idx interface.

---
 rtl/rr_drain_arbiter_pkg.sv | 18 +
 rtl/rr_drain_arbiter_grant4.sv | 28 ++
 rtl/rr_drain_arbiter.sv | 116 +++++++++++
 tb/tb_rr_drain_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_drain_arbiter_pkg.sv
// Shared types and helpers for the round-robin drain arbiter and its grant encoder.
// The grant encoder is also reused by the upstream classifier.
package rr_drain_arbiter_pkg;

    localparam int DATA_W = 10;
    localparam int CNT_W  = 5;
    localparam int NUM_CH = 4;

    typedef logic [1:0] ch_idx_t;

    // Pointer value after reset/init, so that channel 0 is scanned first.
    localparam ch_idx_t LAST_INIT = 2'd3;

    function automatic ch_idx_t next_rr(input ch_idx_t cur);
        return cur + ch_idx_t'(1);
    endfunction

endpackage

// File: rtl/rr_drain_arbiter_grant4.sv
// Combinational 4-request round-robin priority encoder.
// The scan starts at the channel after 'last' and wraps around.
module rr_grant4
    import rr_drain_arbiter_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  ch_idx_t           last,
    output logic              gnt_v,
    output ch_idx_t           gnt_idx
);

    ch_idx_t cand;

    always_comb begin
        gnt_v   = 1'b0;
        gnt_idx = last;
        cand    = last;
        // 'last' itself is the final candidate, so a lone requester can win back-to-back.
        for (int i = 0; i < NUM_CH; i++) begin
            cand = next_rr(cand);
            if (!gnt_v && req[cand]) begin
                gnt_v   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

endmodule

// File: rtl/rr_drain_arbiter.sv
// Drains four virtual-channel FIFOs round-robin into one word stream.
// Keeps a per-channel forwarded-word counter that can be read through req/idx.
module rr_drain_arbiter #(
    parameter int DATA_W = rr_drain_arbiter_pkg::DATA_W,
    parameter int CNT_W  = rr_drain_arbiter_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic [DATA_W-1:0] data_in2,
    input  logic [DATA_W-1:0] data_in3,
    input  logic              empty0,
    input  logic              empty1,
    input  logic              empty2,
    input  logic              empty3,
    input  logic              pause,
    input  logic              req,
    input  logic [1:0]        idx,
    output logic              pop0,
    output logic              pop1,
    output logic              pop2,
    output logic              pop3,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic [CNT_W-1:0]  contador,
    output logic              contador_valid
);

    import rr_drain_arbiter_pkg::NUM_CH;
    import rr_drain_arbiter_pkg::ch_idx_t;
    import rr_drain_arbiter_pkg::LAST_INIT;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    ch_idx_t           last;
    logic              pend_v;
    ch_idx_t           pend_ch;
    logic [CNT_W-1:0]  count [NUM_CH];
    logic [NUM_CH-1:0] fifo_req;
    logic              gnt_v;
    ch_idx_t           gnt_idx;
    logic [DATA_W-1:0] data_sel;

    // Pause gates requests directly so it blocks pops in the same cycle.
    assign fifo_req = {~empty3, ~empty2, ~empty1, ~empty0} & {NUM_CH{~pause}};

    rr_grant4 u_grant (
        .req     (fifo_req),
        .last    (last),
        .gnt_v   (gnt_v),
        .gnt_idx (gnt_idx)
    );

    assign pop0 = reset & gnt_v & (gnt_idx == ch_idx_t'(0));
    assign pop1 = reset & gnt_v & (gnt_idx == ch_idx_t'(1));
    assign pop2 = reset & gnt_v & (gnt_idx == ch_idx_t'(2));
    assign pop3 = reset & gnt_v & (gnt_idx == ch_idx_t'(3));

    always_comb begin
        data_sel = data_in0;
        case (pend_ch)
            2'd1:    data_sel = data_in1;
            2'd2:    data_sel = data_in2;
            2'd3:    data_sel = data_in3;
            default: data_sel = data_in0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last           <= LAST_INIT;
            pend_v         <= 1'b0;
            pend_ch        <= '0;
            data_out       <= '0;
            data_valid     <= 1'b0;
            contador       <= '0;
            contador_valid <= 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                count[ch] <= '0;
            end
        end else begin
            pend_v <= gnt_v;
            if (gnt_v) begin
                pend_ch <= gnt_idx;
            end

            if (init) begin
                last <= LAST_INIT;
            end else if (gnt_v) begin
                last <= gnt_idx;
            end

            data_valid <= pend_v;
            if (pend_v) begin
                data_out <= data_sel;
            end

            // Reads see the count from before this edge's increment.
            contador_valid <= req;
            if (req) begin
                contador <= count[idx];
            end

            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (init) begin
                    count[ch] <= '0;
                end else if (pend_v && (pend_ch == ch_idx_t'(ch))) begin
                    count[ch] <= count[ch] + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_drain_arbiter.sv
// Self-checking bench for rr_drain_arbiter: bench-side FIFOs feed the DUT and a
// queue-based reference model predicts pops, the output stream and counter reads.
module tb_rr_drain_arbiter;

    localparam int DW = 10;
    localparam int CW = 5;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          init  = 1'b0;
    logic          pause = 1'b0;
    logic          req   = 1'b0;
    logic [1:0]    idx   = 2'd0;
    logic [DW-1:0] dreg [4];
    logic [3:0]    emp;

    logic          pop0, pop1, pop2, pop3;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic [CW-1:0] contador;
    logic          contador_valid;

    always #5 clk = ~clk;

    rr_drain_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .init           (init),
        .data_in0       (dreg[0]),
        .data_in1       (dreg[1]),
        .data_in2       (dreg[2]),
        .data_in3       (dreg[3]),
        .empty0         (emp[0]),
        .empty1         (emp[1]),
        .empty2         (emp[2]),
        .empty3         (emp[3]),
        .pause          (pause),
        .req            (req),
        .idx            (idx),
        .pop0           (pop0),
        .pop1           (pop1),
        .pop2           (pop2),
        .pop3           (pop3),
        .data_out       (data_out),
        .data_valid     (data_valid),
        .contador       (contador),
        .contador_valid (contador_valid)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Bench-side FIFOs (ring buffers) and the reference model state.
    logic [DW-1:0] mem [4][64];
    int rd [4];
    int wr [4];
    int m_last;
    int m_cnt [4];
    int eq_due [$];
    int eq_word [$];
    int eq_ch [$];
    logic [31:0] exp_do;
    logic [31:0] exp_cont;
    logic        exp_dv;
    logic        exp_cv;
    int cyc;
    int last_g;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int ch, input int w);
        mem[ch][wr[ch] % 64] = DW'(w);
        wr[ch]++;
    endtask

    task automatic upd_emp();
        for (int ch = 0; ch < 4; ch++) emp[ch] = (rd[ch] == wr[ch]);
    endtask

    task automatic model_reset();
        m_last = 3;
        for (int ch = 0; ch < 4; ch++) m_cnt[ch] = 0;
        eq_due.delete();
        eq_word.delete();
        eq_ch.delete();
        exp_do   = 0;
        exp_cont = 0;
        exp_dv   = 1'b0;
        exp_cv   = 1'b0;
    endtask

    // One clock cycle; called at a falling edge with inputs already driven.
    task automatic step();
        int g;
        int ch;
        logic [3:0] pv;
        logic sreq, sinit;
        logic [1:0] sidx;
        upd_emp();
        #1;
        g = -1;
        if (!pause) begin
            for (int k = 1; k <= 4; k++) begin
                ch = (m_last + k) % 4;
                if (g < 0 && wr[ch] != rd[ch]) g = ch;
            end
        end
        pv = {pop3, pop2, pop1, pop0};
        check("pop", 32'(pv), (g < 0) ? 32'd0 : (32'd1 << g));
        sreq  = req;
        sidx  = idx;
        sinit = init;
        if (g >= 0) begin
            eq_due.push_back(cyc + 2);
            eq_word.push_back(int'(mem[g][rd[g] % 64]));
            eq_ch.push_back(g);
        end
        last_g = g;
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < 4; c++) begin
            if (pv[c] && rd[c] != wr[c]) begin
                dreg[c] = mem[c][rd[c] % 64];
                rd[c]++;
            end
        end
        upd_emp();
        exp_cv = sreq;
        if (sreq) exp_cont = m_cnt[sidx];
        exp_dv = 1'b0;
        if (eq_due.size() > 0 && eq_due[0] == cyc) begin
            exp_dv = 1'b1;
            exp_do = eq_word[0];
            ch     = eq_ch[0];
            void'(eq_due.pop_front());
            void'(eq_word.pop_front());
            void'(eq_ch.pop_front());
            m_cnt[ch] = (m_cnt[ch] + 1) % 32;
        end
        if (g >= 0) m_last = g;
        if (sinit) begin
            m_last = 3;
            for (int c = 0; c < 4; c++) m_cnt[c] = 0;
        end
        check("data_valid", 32'(data_valid), 32'(exp_dv));
        check("data_out", 32'(data_out), exp_do);
        check("contador_valid", 32'(contador_valid), 32'(exp_cv));
        check("contador", 32'(contador), exp_cont);
        @(negedge clk);
    endtask

    initial begin
        for (int ch = 0; ch < 4; ch++) begin
            rd[ch]   = 0;
            wr[ch]   = 0;
            dreg[ch] = '0;
        end
        cyc    = 0;
        last_g = -1;
        model_reset();
        upd_emp();

        // Reset state
        #3;
        check("rst_pops", 32'({pop3, pop2, pop1, pop0}), 32'd0);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_contador", 32'(contador), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // All FIFOs empty: no pops, counters read zero
        for (int k = 0; k < 5; k++) begin
            req = 1'b1;
            idx = 2'(k);
            step();
        end
        req = 1'b0;

        // One word per channel: pops 0,1,2,3 then data two cycles later
        push(0, 'h001);
        push(1, 'h102);
        push(2, 'h203);
        push(3, 'h304);
        step();
        check("first_gnt_ch0", 32'(last_g), 32'd0);
        repeat (5) step();
        for (int k = 0; k < 4; k++) begin
            req = 1'b1;
            idx = 2'(k);
            step();
            check("cnt_after_one_word", 32'(contador), 32'd1);
        end
        req = 1'b0;
        step();

        // Only channel 2: back-to-back grants
        push(2, 'h2a1);
        push(2, 'h2a2);
        push(2, 'h2a3);
        repeat (6) step();

        // All channels busy, pause right after the grant to ch1
        for (int ch = 0; ch < 4; ch++)
            for (int n = 0; n < 4; n++) push(ch, 'h100 * ch + 'h40 + n);
        for (int k = 0; k < 8; k++) begin
            step();
            if (last_g == 1) break;
        end
        check("gnt_ch1_seen", 32'(last_g), 32'd1);
        pause = 1'b1;
        repeat (3) step();
        pause = 1'b0;
        step();
        check("resume_gnt_ch2", 32'(last_g), 32'd2);
        repeat (20) step();

        // Counter wrap on ch0: 33 words from zero
        init = 1'b1;
        step();
        init = 1'b0;
        for (int n = 0; n < 33; n++) push(0, 'h3c0 + n);
        repeat (38) step();
        req = 1'b1;
        idx = 2'd0;
        step();
        check("wrap_cnt0", 32'(contador), 32'd1);
        req = 1'b0;

        // Init clears counters and rewinds the pointer
        push(2, 'h0f2);
        repeat (4) step();
        init = 1'b1;
        step();
        init = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req = 1'b1;
            idx = 2'(k);
            step();
            check("init_cnt", 32'(contador), 32'd0);
        end
        req = 1'b0;
        push(2, 'h1f2);
        push(0, 'h1f0);
        step();
        check("post_init_gnt_ch0", 32'(last_g), 32'd0);
        repeat (4) step();

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            for (int ch = 0; ch < 4; ch++)
                if ($urandom_range(0, 3) == 0 && (wr[ch] - rd[ch]) < 60)
                    push(ch, int'($urandom_range(0, 1023)));
            pause = ($urandom_range(0, 3) == 0);
            req   = $urandom_range(0, 1) == 1;
            idx   = 2'($urandom_range(0, 3));
            init  = ($urandom_range(0, 40) == 0);
            step();
        end
        pause = 1'b0;
        init  = 1'b0;
        req   = 1'b0;
        repeat (60) step();

        // Asynchronous reset while a word is pending
        push(3, 'h3aa);
        push(1, 'h1bb);
        push(2, 'h2cc);
        step();
        req = 1'b1;
        step();
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_pops", 32'({pop3, pop2, pop1, pop0}), 32'd0);
        check("async_rst_data_valid", 32'(data_valid), 32'd0);
        check("async_rst_data_out", 32'(data_out), 32'd0);
        check("async_rst_contador", 32'(contador), 32'd0);
        check("async_rst_contador_valid", 32'(contador_valid), 32'd0);
        @(posedge clk);
        #1;
        check("rst_held_data_valid", 32'(data_valid), 32'd0);
        @(negedge clk);
        req   = 1'b0;
        reset = 1'b1;
        model_reset();
        repeat (6) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
